platform_field: RTL and testbench

- Owns the 16-entry platform position table. It generates, scrolls and respawns platforms, and serves their X/Y positions to the pixel colour path over an indexed read port.
- Emits the `loadplat` strobe that tells consumers the table is consistent.
- Sits between the game-state logic (scroll requests) and the colour mapper (position reader). It replaces the free-running per-platform LFSR sampling on the mapper side.

---
 rtl/doodle_pkg.sv | 12 +
 rtl/platform_field_lfsr10.sv | 15 +
 rtl/platform_field.sv | 131 +++++++++++++
 tb/tb_platform_field.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg: shared screen constants, platform record, FSM states and LFSR taps
package doodle_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  // x^10 + x^7 + 1 : feedback from bits 9 and 6
  localparam logic [9:0] LFSR_TAPS = 10'h240;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } plat_t;
  typedef enum logic [1:0] {IDLE, INIT, READY, SCROLL} state_t;
endpackage

// File: rtl/platform_field_lfsr10.sv
// lfsr10: free-running 10-bit Fibonacci LFSR (x^10+x^7+1), shifts every cycle
// Ports: Clk, Reset (async, active-high, loads SEED), out[9:0] current state.
module lfsr10
  import doodle_pkg::*;
#(
  parameter logic [9:0] SEED = 10'h001
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] out
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) out <= SEED;
    else out <= {out[8:0], ^(out & LFSR_TAPS)};
endmodule

// File: rtl/platform_field.sv
// platform_field: 16-slot platform position table with init, scroll/respawn and registered read port
// Ports: Clk, Reset (async, active-high); frame_clk (async level, synchronised here);
//   init (pulse, regenerate field); scroll_amt[3:0] (lines per frame, 0 = none);
//   rd_idx[3:0] -> rd_x[9:0]/rd_y[9:0] one cycle later; loadplat (table consistent pulse);
//   busy (INIT or SCROLL); respawn_cnt[7:0] (wrapping); overrun (sticky, frame during SCROLL).
// Optional: define PLATFORM_FIELD_DBUF_EN to read from a shadow table refreshed on loadplat.
module platform_field
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT     = 16,
  parameter int PLAT_SPACING = 30,
  parameter int PLAT_Y0      = 15,
  parameter int X_OFFSET     = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       init,
  input  logic [3:0] scroll_amt,
  input  logic [3:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  output logic       loadplat,
  output logic       busy,
  output logic [7:0] respawn_cnt,
  output logic       overrun
);
  localparam int IW = $clog2(NUM_PLAT);
  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [3:0] amt, amt_nxt;
  logic [9:0] lfsr, new_x, sum;
  logic fs1, fs2, fs_prev, frame_edge;
  logic wr_en, load_nxt, respawn, ovr_set, wrap, last;
  plat_t tbl [NUM_PLAT];
  plat_t wr_val, cur, rd_src;

  lfsr10 #(.SEED(10'h001)) u_lfsr (.Clk(Clk), .Reset(Reset), .out(lfsr));

  assign frame_edge = fs2 & ~fs_prev;
  assign new_x      = (lfsr & 10'h1ff) + 10'(X_OFFSET);
  assign cur        = tbl[idx];
  assign sum        = cur.y + {6'd0, amt};
  assign wrap       = sum >= 10'(SCREEN_H);
  assign last       = idx == IW'(NUM_PLAT - 1);
  assign busy       = state == INIT || state == SCROLL;

  // init overrides everything, including an in-flight scroll and a coincident frame edge
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    amt_nxt   = amt;
    wr_en     = 1'b0;
    wr_val    = '0;
    load_nxt  = 1'b0;
    respawn   = 1'b0;
    ovr_set   = 1'b0;
    if (init) begin
      state_nxt = INIT;
      idx_nxt   = '0;
    end else begin
      case (state)
        INIT: begin
          wr_en    = 1'b1;
          wr_val   = plat_t'{x: new_x, y: 10'(PLAT_Y0 + PLAT_SPACING * int'(idx))};
          idx_nxt  = idx + 1'b1;
          state_nxt = last ? READY : INIT;
          load_nxt = last;
        end
        READY: if (frame_edge && scroll_amt != 4'd0) begin
          state_nxt = SCROLL;
          idx_nxt   = '0;
          amt_nxt   = scroll_amt;
        end
        SCROLL: begin
          wr_en    = 1'b1;
          wr_val   = wrap ? plat_t'{x: new_x, y: sum - 10'(SCREEN_H)} : plat_t'{x: cur.x, y: sum};
          respawn  = wrap;
          ovr_set  = frame_edge;
          idx_nxt  = idx + 1'b1;
          state_nxt = last ? READY : SCROLL;
          load_nxt = last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state       <= IDLE;
      idx         <= '0;
      amt         <= '0;
      loadplat    <= 1'b0;
      respawn_cnt <= '0;
      overrun     <= 1'b0;
      fs1         <= 1'b0;
      fs2         <= 1'b0;
      fs_prev     <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      for (int i = 0; i < NUM_PLAT; i++) tbl[i] <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      amt         <= amt_nxt;
      loadplat    <= load_nxt;
      respawn_cnt <= respawn_cnt + 8'(respawn);
      overrun     <= overrun | ovr_set;
      fs1         <= frame_clk;
      fs2         <= fs1;
      fs_prev     <= fs2;
      rd_x        <= rd_src.x;
      rd_y        <= rd_src.y;
      if (wr_en) tbl[idx] <= wr_val;
    end

`ifdef PLATFORM_FIELD_DBUF_EN
  plat_t shadow [NUM_PLAT];
  // snapshot includes the slot being written in the same cycle so the copy is complete
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      for (int i = 0; i < NUM_PLAT; i++) shadow[i] <= '0;
    end else if (load_nxt) begin
      for (int i = 0; i < NUM_PLAT; i++) shadow[i] <= (wr_en && idx == IW'(i)) ? wr_val : tbl[i];
    end
  assign rd_src = shadow[rd_idx];
`else
  assign rd_src = tbl[rd_idx];
`endif
endmodule

// File: tb/tb_platform_field.sv
// tb_platform_field: directed self-checking bench for platform_field
module tb_platform_field;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, init = 1'b0;
  logic [3:0] scroll_amt = '0, rd_idx = '0;
  logic [9:0] rd_x, rd_y;
  logic loadplat, busy, overrun;
  logic [7:0] respawn_cnt;
  logic [9:0] m_lfsr;
  int total = 0, bad = 0, exp_resp = 0, lp;
  int ey [16], ex [16];

  platform_field dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .init(init),
    .scroll_amt(scroll_amt), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .loadplat(loadplat), .busy(busy), .respawn_cnt(respawn_cnt), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) m_lfsr <= 10'h001;
    else m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // caller sits at a negedge; slot k is written with the LFSR value seen k+1 negedges later
  task automatic do_init();
    init = 1'b1;
    @(negedge Clk);
    init = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ey[k] = 15 + 30 * k;
      ex[k] = int'(m_lfsr[8:0]) + 64;
      chk($sformatf("init_busy%0d", k), busy, 1);
      chk($sformatf("init_noload%0d", k), loadplat, 0);
      @(negedge Clk);
    end
    chk("init_loadplat", loadplat, 1);
    chk("init_done_busy", busy, 0);
    @(negedge Clk);
    chk("init_loadplat_off", loadplat, 0);
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      @(negedge Clk);
      chk($sformatf("%s_y%0d", tag, k), rd_y, ey[k]);
      chk($sformatf("%s_x%0d", tag, k), rd_x, ex[k]);
      chk($sformatf("%s_xrange%0d", tag, k), 32'(rd_x >= 10'd64 && rd_x <= 10'd575), 1);
    end
  endtask

  // n counts negedges after frame_clk rises; slot k is processed at n = k + 3, loadplat at n = 19
  task automatic run_scroll(input logic [3:0] amt, input bit ovr, input bit abort, input bit probe3,
                            output int lp_at);
    int k, s;
    scroll_amt = amt;
    frame_clk  = 1'b1;
    lp_at      = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (abort && n == 11) begin
        do_init();
        break;
      end
      if (ovr && n == 4) frame_clk = 1'b0;
      if (ovr && n == 6) frame_clk = 1'b1;
      if (n >= 3 && n <= 18) begin
        k = n - 3;
        s = ey[k] + int'(amt);
        if (s >= 480) begin
          ey[k] = s - 480;
          ex[k] = int'(m_lfsr[8:0]) + 64;
          exp_resp++;
        end else ey[k] = s;
      end
      if (probe3 && n == 7) chk("slot3_before_write", rd_y, 105);
`ifdef PLATFORM_FIELD_DBUF_EN
      if (probe3 && n == 8) chk("slot3_shadow_held", rd_y, 105);
`else
      if (probe3 && n == 8) chk("slot3_live", rd_y, 115);
`endif
      if (loadplat) begin
        lp_at = n;
`ifdef PLATFORM_FIELD_DBUF_EN
        if (probe3) chk("slot3_at_load", rd_y, 105);
`else
        if (probe3) chk("slot3_at_load", rd_y, 115);
`endif
        break;
      end
    end
    frame_clk = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0);
    chk("rst_loadplat", loadplat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_respawn", respawn_cnt, 0);
    chk("rst_overrun", overrun, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_busy", busy, 0);
    do_init();
    chk_all("init");

    // frame edges with zero scroll leave the field alone
    scroll_amt = 4'd0;
    frame_clk  = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge Clk);
      chk("amt0_noload", loadplat, 0);
      chk("amt0_busy", busy, 0);
    end
    frame_clk = 1'b0;
    rd_idx = 4'd3;
    repeat (4) @(negedge Clk);
    chk("slot3_init_y", rd_y, 105);

    run_scroll(4'd10, 1'b0, 1'b0, 1'b1, lp);
    chk("scroll1_latency", lp, 19);
    @(negedge Clk);
    chk("scroll1_loadplat_off", loadplat, 0);
    chk("scroll1_respawn", respawn_cnt, 0);
    chk("scroll1_overrun", overrun, 0);
    chk_all("scroll1");
    chk("scroll1_slot15_y", ey[15], 475);

    run_scroll(4'd10, 1'b0, 1'b0, 1'b0, lp);
    chk("scroll2_latency", lp, 19);
    chk("scroll2_respawn", respawn_cnt, 1);
    chk("scroll2_model_respawn", respawn_cnt, exp_resp);
    chk_all("scroll2");
    chk("scroll2_slot15_y", ey[15], 5);

    run_scroll(4'd10, 1'b1, 1'b0, 1'b0, lp);
    chk("scroll3_latency", lp, 19);
    chk("scroll3_overrun", overrun, 1);
    chk("scroll3_respawn", respawn_cnt, 1);
    chk_all("scroll3");
    chk("scroll3_overrun_sticky", overrun, 1);

    run_scroll(4'd10, 1'b0, 1'b1, 1'b0, lp);
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      chk("abort_no_extra_load", loadplat, 0);
    end
    chk("abort_busy", busy, 0);
    chk("abort_respawn", respawn_cnt, 1);
    chk_all("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
